// File: rtl/div_seq_unit_if.sv
// Handshake and operand/result bundle between the control unit and the
// sequential divider.
//   DivCtrl  start request (level, held while the control unit waits)
//   a, b     dividend / divisor, two's complement
//   hi, lo   remainder / quotient
//   DivOut   one-cycle done pulse
//   divZero  one-cycle divide-by-zero pulse
//   busy     divider is iterating or fixing signs
// master: the control unit side; slave: the divider side.
interface div_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             DivCtrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             DivOut;
  logic             divZero;
  logic             busy;

  modport master (
    output DivCtrl, a, b,
    input  hi, lo, DivOut, divZero, busy
  );

  modport slave (
    input  DivCtrl, a, b,
    output hi, lo, DivOut, divZero, busy
  );
endinterface

// File: rtl/div_seq_unit.sv
// Multicycle signed divider (radix-2 restoring, one quotient bit per clock)
// answering the control unit's DIV start/done handshake.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high; clears all state and outputs
//   div_bus  slave side of div_seq_unit_if (DivCtrl, a, b in;
//            hi, lo, DivOut, divZero, busy out)
// Quotient goes to lo (truncated toward zero), remainder to hi (sign of the
// dividend). -2^(W-1) / -1 wraps to lo = -2^(W-1), hi = 0.
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  div_seq_unit_if.slave div_bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic             div_out_q, div_out_d;
  logic             div_zero_q, div_zero_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // Unsigned magnitudes fit in WIDTH bits even for -2^(W-1) (0x80..0).
  // The remainder is always below the divisor, so the shifted partial
  // remainder and the trial difference both fit in WIDTH+1 bits and
  // trial[WIDTH] is a valid sign.
  always_comb begin
    mag_a  = div_bus.a[WIDTH-1] ? -div_bus.a : div_bus.a;
    mag_b  = div_bus.b[WIDTH-1] ? -div_bus.b : div_bus.b;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    count_d    = count_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    div_out_d  = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_bus.DivCtrl) begin
          if (div_bus.b == '0) begin
            div_zero_d = 1'b1;
            state_d    = HOLD;
          end else begin
            sign_quo_d = div_bus.a[WIDTH-1] ^ div_bus.b[WIDTH-1];
            sign_rem_d = div_bus.a[WIDTH-1];
            rem_d      = '0;
            quo_d      = mag_a;
            dvs_d      = mag_b;
            count_d    = '0;
            state_d    = CALC;
          end
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          state_d = FIX;
        end
      end

      FIX: begin
        lo_d      = sign_quo_q ? -quo_q : quo_q;
        hi_d      = sign_rem_q ? -rem_q : rem_q;
        div_out_d = 1'b1;
        state_d   = HOLD;
      end

      HOLD: begin
        // A start level that stays high must not retrigger.
        if (!div_bus.DivCtrl) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      count_q    <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      div_out_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      count_q    <= count_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      div_out_q  <= div_out_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
    end
  end

  assign div_bus.hi      = hi_q;
  assign div_bus.lo      = lo_q;
  assign div_bus.DivOut  = div_out_q;
  assign div_bus.divZero = div_zero_q;
  assign div_bus.busy    = busy_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: directed vectors with hand-computed
// results (sign combinations, divide-by-zero, -2^31 corner cases, held start
// level, mid-operation reset) followed by a short batch of random vectors
// checked against the language's signed / and %.
module tb_div_seq_unit;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  div_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  div_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .div_bus (bus)
  );

  always #5 clk = ~clk;

  int compare_count  = 0;
  int mismatch_count = 0;

  int lat;
  int busy_cycles;
  int out_pulses;
  int zero_pulses;
  int zero_first;
  int overlap;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Raises DivCtrl with the given operands just before a rising edge (T0)
  // and watches hold_cycles following cycles, sampling at falling edges.
  // Sample i corresponds to the cycle after edge T(i-1), so a DivOut that
  // rises on edge T33 is seen at i = 34. Operands are scrambled during the
  // operation; drop_early releases DivCtrl mid-calculation.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               input int hold_cycles, input bit drop_early);
    @(negedge clk);
    bus.a       = av;
    bus.b       = bv;
    bus.DivCtrl = 1'b1;
    lat         = 0;
    busy_cycles = 0;
    out_pulses  = 0;
    zero_pulses = 0;
    zero_first  = 0;
    overlap     = 0;
    for (int i = 1; i <= hold_cycles; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      if (bus.DivOut) begin
        out_pulses++;
        if (lat == 0) lat = i;
      end
      if (bus.divZero) begin
        zero_pulses++;
        if (zero_first == 0) zero_first = i;
      end
      if (bus.DivOut && bus.divZero) overlap++;
      if (i == 3) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      if (drop_early && i == 5) bus.DivCtrl = 1'b0;
    end
    bus.DivCtrl = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra, rb, exp_q, exp_r;
    int tmp;

    reset       = 1'b1;
    bus.DivCtrl = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_hi", bus.hi, 32'h0);
    checkOutput("reset_lo", bus.lo, 32'h0);
    checkOutput("reset_DivOut", {31'b0, bus.DivOut}, 32'h0);
    checkOutput("reset_divZero", {31'b0, bus.divZero}, 32'h0);
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'h0);
    reset = 1'b0;

    // 100 / 7, start held high well beyond completion.
    applyStimulus(32'd100, 32'd7, 134, 1'b0);
    checkOutput("t1_latency", 32'(lat), 32'd34);
    checkOutput("t1_lo", bus.lo, 32'd14);
    checkOutput("t1_hi", bus.hi, 32'd2);
    checkOutput("t1_busy_cycles", 32'(busy_cycles), 32'd33);
    checkOutput("t1_single_pulse", 32'(out_pulses), 32'd1);
    checkOutput("t1_no_zero", 32'(zero_pulses), 32'd0);

    applyStimulus(-32'sd100, 32'd7, 40, 1'b0);
    checkOutput("t2a_lo", bus.lo, 32'hFFFF_FFF2);
    checkOutput("t2a_hi", bus.hi, 32'hFFFF_FFFE);
    applyStimulus(32'd100, -32'sd7, 40, 1'b0);
    checkOutput("t2b_lo", bus.lo, 32'hFFFF_FFF2);
    checkOutput("t2b_hi", bus.hi, 32'd2);

    // Divide by zero keeps the previous results.
    applyStimulus(32'd5, 32'd0, 40, 1'b0);
    checkOutput("t3_zero_first", 32'(zero_first), 32'd1);
    checkOutput("t3_zero_pulses", 32'(zero_pulses), 32'd1);
    checkOutput("t3_no_DivOut", 32'(out_pulses), 32'd0);
    checkOutput("t3_busy_cycles", 32'(busy_cycles), 32'd0);
    checkOutput("t3_lo_kept", bus.lo, 32'hFFFF_FFF2);
    checkOutput("t3_hi_kept", bus.hi, 32'd2);

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 40, 1'b0);
    checkOutput("t4a_lo", bus.lo, 32'h8000_0000);
    checkOutput("t4a_hi", bus.hi, 32'h0);
    checkOutput("t4a_no_overlap", 32'(overlap), 32'd0);
    applyStimulus(32'h8000_0000, 32'd1, 40, 1'b1);
    checkOutput("t4b_lo", bus.lo, 32'h8000_0000);
    checkOutput("t4b_hi", bus.hi, 32'h0);
    checkOutput("t4b_pulse_after_drop", 32'(out_pulses), 32'd1);

    applyStimulus(32'd9, 32'd3, 40, 1'b0);
    checkOutput("t5_lo", bus.lo, 32'd3);
    checkOutput("t5_hi", bus.hi, 32'd0);
    checkOutput("t5_pulse", 32'(out_pulses), 32'd1);

    // Reset after CALC step 10 (edges T1..T10 done) of 1234 / 5.
    @(negedge clk);
    bus.a       = 32'd1234;
    bus.b       = 32'd5;
    bus.DivCtrl = 1'b1;
    repeat (11) @(negedge clk);
    checkOutput("t6_busy_before_reset", {31'b0, bus.busy}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("t6_hi_reset", bus.hi, 32'h0);
    checkOutput("t6_lo_reset", bus.lo, 32'h0);
    checkOutput("t6_busy_reset", {31'b0, bus.busy}, 32'h0);
    checkOutput("t6_DivOut_reset", {31'b0, bus.DivOut}, 32'h0);
    checkOutput("t6_divZero_reset", {31'b0, bus.divZero}, 32'h0);
    bus.DivCtrl = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    out_pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.DivOut || bus.divZero || bus.busy) out_pulses++;
    end
    checkOutput("t6_no_activity_after_reset", 32'(out_pulses), 32'd0);
    applyStimulus(32'd1, 32'hFFFF_FFFF, 40, 1'b0);
    checkOutput("t6_lo", bus.lo, 32'hFFFF_FFFF);
    checkOutput("t6_hi", bus.hi, 32'h0);

    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 0) begin
        ra = $urandom;
        rb = $urandom;
      end else begin
        tmp = int'($urandom_range(2000, 0)) - 1000;
        ra  = 32'(tmp);
        tmp = int'($urandom_range(40, 0)) - 20;
        rb  = 32'(tmp);
      end
      if (rb == 32'h0) rb = 32'd3;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
      exp_q = $signed(ra) / $signed(rb);
      exp_r = $signed(ra) % $signed(rb);
      applyStimulus(ra, rb, 36, 1'b0);
      checkOutput($sformatf("rnd%0d_lo", k), bus.lo, exp_q);
      checkOutput($sformatf("rnd%0d_hi", k), bus.hi, exp_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
